// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: HD44780-style LCD bus responder with 32-char screen buffer.
// Ports: clk/rst system clock and async reset; lcd_e/lcd_rs/lcd_rw/lcd_dat_in async bus inputs;
// lcd_dat_out/lcd_dat_oe read return; rd_addr/rd_char debug buffer read; cmd_valid/cmd_byte
// accepted commands; ddram_addr address counter; busy responder busy; overrun sticky error.
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_dat_in,
  output logic [3:0] lcd_dat_out,
  output logic       lcd_dat_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic [4:0] ddram_addr,
  output logic       busy,
  output logic       overrun
);
  localparam int CW = $clog2(BUSY_CYCLES + 1);
  typedef enum logic [1:0] {INIT8, HI, LO} mode_t;
  mode_t mode;
  logic [1:0] e_s, rs_s, rw_s;
  logic [3:0] d_s1, d_s2;
  logic e_d;
  logic [7:0] buffer [32];
  logic id, rs_l, rw_l, clearing;
  logic [3:0] hi, held;
  logic [4:0] clr_idx;
  logic [CW-1:0] cnt;
  logic strobe, wr, acc, mism, rs_c, rd_step;
  logic [7:0] byte_c, rd_byte;
  logic [4:0] step_addr;
  // Strobe is the falling edge of synchronized E; bus fields come from the same stage.
  assign strobe = e_d & ~e_s[1];
  assign wr = strobe & ~rw_s[1] & ~busy;
  // In LO the second half must have the same direction as the latched first half.
  assign mism = (mode == LO) & (rw_l != rw_s[1]);
  assign byte_c = (mode == INIT8) ? {d_s2, 4'h0} : {hi, d_s2};
  assign rs_c = (mode == INIT8) ? rs_s[1] : rs_l;
  assign acc = wr & ((mode == INIT8) | ((mode == LO) & ~mism));
  assign rd_step = strobe & rw_s[1] & (((mode == INIT8) & rs_s[1]) | ((mode == LO) & rs_l & ~mism));
  assign step_addr = id ? ddram_addr + 5'd1 : ddram_addr - 5'd1;
  // Read data is captured one stage early so it is already valid when the enable rises.
  assign rd_byte = rs_s[0] ? buffer[ddram_addr] : {busy, ddram_addr[4], 2'b00, ddram_addr[3:0]};
  assign lcd_dat_oe = e_s[1] & rw_s[1];
  assign lcd_dat_out = lcd_dat_oe ? held : 4'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_s <= '0;
      rs_s <= '0;
      rw_s <= '0;
      d_s1 <= '0;
      d_s2 <= '0;
      e_d <= 1'b0;
      for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
      mode <= INIT8;
      id <= 1'b1;
      rs_l <= 1'b0;
      rw_l <= 1'b0;
      clearing <= 1'b0;
      hi <= '0;
      held <= '0;
      clr_idx <= '0;
      cnt <= '0;
      ddram_addr <= '0;
      busy <= 1'b0;
      overrun <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte <= 8'h00;
      rd_char <= 8'h20;
    end else begin
      e_s <= {e_s[0], lcd_e};
      rs_s <= {rs_s[0], lcd_rs};
      rw_s <= {rw_s[0], lcd_rw};
      d_s1 <= lcd_dat_in;
      d_s2 <= d_s1;
      e_d <= e_s[1];
      rd_char <= buffer[rd_addr];
      if (e_s[0] & rw_s[0] & ~lcd_dat_oe) held <= (mode == LO) ? rd_byte[3:0] : rd_byte[7:4];
      if (strobe) begin
        if (~rw_s[1] & busy) overrun <= 1'b1;
        else if (mode == HI) begin
          hi <= d_s2;
          rs_l <= rs_s[1];
          rw_l <= rw_s[1];
          mode <= LO;
        end else if (mode == LO) begin
          mode <= (acc & ~rs_c & (byte_c[7:4] == 4'b0011)) ? INIT8 : HI;
          if (mism) overrun <= 1'b1;
        end else if (acc & ~rs_c & (byte_c[7:4] == 4'b0010)) mode <= HI;
      end
      if (acc) begin
        cmd_valid <= ~rs_c;
        busy <= 1'b1;
        cnt <= CW'(BUSY_CYCLES);
        if (rs_c) begin
          buffer[ddram_addr] <= byte_c;
          ddram_addr <= step_addr;
        end else begin
          cmd_byte <= byte_c;
          if (byte_c[7]) ddram_addr <= {byte_c[6], byte_c[3:0]};
          else if (byte_c[7:5] == 3'b001) id <= id;
          else if (byte_c[7:2] == 6'b000001) id <= byte_c[1];
          else if (byte_c[7:1] == 7'b0000001) ddram_addr <= '0;
          else if (byte_c == 8'h01) begin
            clearing <= 1'b1;
            clr_idx <= '0;
          end
        end
      end else begin
        cmd_valid <= 1'b0;
        cnt <= (cnt != '0) ? cnt - CW'(1) : cnt;
        busy <= (cnt > CW'(1)) | (clearing & (clr_idx != 5'd31));
        if (rd_step) ddram_addr <= step_addr;
      end
      if (clearing) begin
        buffer[clr_idx] <= 8'h20;
        clr_idx <= clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          clearing <= 1'b0;
          ddram_addr <= '0;
          id <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: scoreboard bench for lcd_bus_receiver.
module tb_lcd_bus_receiver;
  logic clk = 0, rst = 1, lcd_e = 0, lcd_rs = 0, lcd_rw = 0;
  logic [3:0] lcd_dat_in = 0, lcd_dat_out;
  logic lcd_dat_oe, cmd_valid, busy, overrun;
  logic [4:0] rd_addr = 0, ddram_addr;
  logic [7:0] rd_char, cmd_byte;
  int checks = 0, errors = 0, run_len = 0, last_len = 0;
  logic oe_prev = 0;
  logic [7:0] cmd_q[$];
  logic [3:0] rd_q[$];

  lcd_bus_receiver dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_dat_in(lcd_dat_in), .lcd_dat_out(lcd_dat_out), .lcd_dat_oe(lcd_dat_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .ddram_addr(ddram_addr), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      checks++;
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got %0h expected none", cmd_byte);
      end else begin
        logic [7:0] e;
        e = cmd_q.pop_front();
        if (cmd_byte !== e) begin
          errors++;
          $display("FAIL cmd_byte: got %0h expected %0h", cmd_byte, e);
        end
      end
    end
    if (!rst && lcd_dat_oe && !oe_prev) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected none", lcd_dat_out);
      end else begin
        logic [3:0] e;
        e = rd_q.pop_front();
        if (lcd_dat_out !== e) begin
          errors++;
          $display("FAIL rd_nibble: got %0h expected %0h", lcd_dat_out, e);
        end
      end
    end
    oe_prev <= lcd_dat_oe;
    if (busy) run_len <= run_len + 1;
    else begin
      if (run_len != 0) last_len <= run_len;
      run_len <= 0;
    end
  end

  task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
    lcd_rs = rs; lcd_rw = rw; lcd_dat_in = d;
    repeat (2) @(negedge clk);
    lcd_e = 1;
    repeat (5) @(negedge clk);
    lcd_e = 0;
    repeat (4) @(negedge clk);
    lcd_rw = 0;
  endtask

  task automatic wr8(input logic [3:0] d);
    cmd_q.push_back({d, 4'h0});
    nib(0, 0, d);
  endtask

  task automatic wr4(input logic rs, input logic [7:0] b, input bit expect_cmd);
    if (expect_cmd && !rs) cmd_q.push_back(b);
    nib(rs, 0, b[7:4]);
    nib(rs, 0, b[3:0]);
  endtask

  task automatic rd4(input logic rs, input logic [7:0] exp);
    rd_q.push_back(exp[7:4]);
    rd_q.push_back(exp[3:0]);
    nib(rs, 1, 0);
    nib(rs, 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got 1 expected 0");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic peek(input logic [4:0] a, input logic [7:0] exp, input string name);
    rd_addr = a;
    repeat (2) @(negedge clk);
    chk(name, rd_char, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_addr", ddram_addr, 0);
    chk("rst_rd_char", rd_char, 8'h20);
    chk("rst_oe", {lcd_dat_oe, lcd_dat_out}, 0);
    rst = 0;
    @(negedge clk);
    wr8(4'h3);
    chk("busy_after_byte", busy, 1);
    wait_idle();
    chk("busy_len", last_len, 40);
    wr8(4'h3); wait_idle();
    wr8(4'h3); wait_idle();
    wr8(4'h2); wait_idle();
    wr4(0, 8'h28, 1); wait_idle();
    wr4(0, 8'h06, 1); wait_idle();
    chk("init_cmd_byte", cmd_byte, 8'h06);
    wr4(0, 8'h8F, 1); wait_idle();
    chk("set_addr_15", ddram_addr, 15);
    wr4(1, 8'h41, 0); wait_idle();
    wr4(1, 8'h42, 0); wait_idle();
    chk("addr_17", ddram_addr, 17);
    peek(15, 8'h41, "buf15_A");
    peek(16, 8'h42, "buf16_B");
    wr4(0, 8'h04, 1); wait_idle();
    wr4(0, 8'h80, 1); wait_idle();
    wr4(1, 8'h5A, 0); wait_idle();
    peek(0, 8'h5A, "buf0_Z");
    chk("addr_wrap_31", ddram_addr, 31);
    wr4(0, 8'h80, 1); wait_idle();
    rd4(1, 8'h5A);
    chk("read_step_down", ddram_addr, 31);
    wr4(0, 8'h06, 1); wait_idle();
    wr4(0, 8'h01, 1);
    wait_idle();
    chk("clear_busy_len", last_len, 40);
    chk("clear_addr", ddram_addr, 0);
    for (int i = 0; i < 32; i++) peek(i[4:0], 8'h20, "clear_buf");
    wr4(0, 8'hC5, 1);
    wr4(1, 8'h51, 0);
    chk("overrun_set", overrun, 1);
    chk("overrun_addr", ddram_addr, 5'h15);
    peek(5'h15, 8'h20, "overrun_buf");
    wait_idle();
    wr4(0, 8'hC5, 1);
    rd4(0, 8'hC5);
    wait_idle();
    rd4(0, 8'h45);
    chk("status_no_step", ddram_addr, 5'h15);
    wr4(0, 8'h01, 1);
    repeat (9) @(negedge clk);
    chk("mid_clear_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_cmd_byte", cmd_byte, 8'h00);
    chk("arst_addr", ddram_addr, 0);
    chk("arst_rd_char", rd_char, 8'h20);
    chk("arst_cmd_valid", cmd_valid, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    wr8(4'h2); wait_idle();
    nib(0, 0, 4'h2);
    rd_q.push_back(4'h0);
    nib(0, 1, 4'h0);
    chk("mismatch_overrun", overrun, 1);
    chk("mismatch_no_busy", busy, 0);
    wr4(0, 8'h06, 1); wait_idle();
    chk("after_mismatch_cmd", cmd_byte, 8'h06);
    chk("sb_empty", cmd_q.size() + rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
